// File: rtl/axi_lite_to_axi_tracked.sv
// AXI4-Lite slave to AXI4 master bridge with per-direction outstanding-transaction limits.
// Define AXI_LITE_TO_AXI_RESP_SPILL_EN to register the B and R channels through two-entry spill buffers.

package axi_lite_to_axi_tracked_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        prot;
    } lite_ax_t;

    typedef struct packed {
        lite_ax_t              aw;
        logic                  aw_valid;
        logic [DATA_W-1:0]     w_data;
        logic [DATA_W/8-1:0]   w_strb;
        logic                  w_valid;
        logic                  b_ready;
        lite_ax_t              ar;
        logic                  ar_valid;
        logic                  r_ready;
    } lite_req_t;

    typedef struct packed {
        logic                  aw_ready;
        logic                  w_ready;
        logic [1:0]            b_resp;
        logic                  b_valid;
        logic                  ar_ready;
        logic [DATA_W-1:0]     r_data;
        logic [1:0]            r_resp;
        logic                  r_valid;
    } lite_resp_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } full_aw_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } full_ar_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } full_w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } full_b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } full_r_t;

    typedef struct packed {
        full_aw_t aw;
        logic     aw_valid;
        full_w_t  w;
        logic     w_valid;
        logic     b_ready;
        full_ar_t ar;
        logic     ar_valid;
        logic     r_ready;
    } full_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        full_b_t b;
        logic    b_valid;
        full_r_t r;
        logic    r_valid;
    } full_resp_t;
endpackage

`ifdef AXI_LITE_TO_AXI_RESP_SPILL_EN
module axi_lite_to_axi_tracked_spill #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    logic [1:0][Width-1:0] mem_q, mem_d;
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push, pop;

    // in_ready depends only on the stored count, so the upstream ready never sees out_ready_i.
    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
`endif

module axi_lite_to_axi_tracked #(
    parameter int unsigned           AxiAddrWidth    = 32'd0,
    parameter int unsigned           AxiDataWidth    = 32'd0,
    parameter int unsigned           AxiIdWidth      = 32'd0,
    parameter int unsigned           AxiUserWidth    = 32'd0,
    parameter int unsigned           AxiMaxWriteTxns = 32'd4,
    parameter int unsigned           AxiMaxReadTxns  = 32'd4,
    parameter logic [AxiIdWidth-1:0] WriteId         = '0,
    parameter logic [AxiIdWidth-1:0] ReadId          = '0,
    parameter logic [3:0]            AxCache         = 4'b0000,
    parameter type lite_req_t  = axi_lite_to_axi_tracked_pkg::lite_req_t,
    parameter type lite_resp_t = axi_lite_to_axi_tracked_pkg::lite_resp_t,
    parameter type full_req_t  = axi_lite_to_axi_tracked_pkg::full_req_t,
    parameter type full_resp_t = axi_lite_to_axi_tracked_pkg::full_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  lite_req_t  slv_req_i,
    output lite_resp_t slv_resp_o,
    output full_req_t  mst_req_o,
    input  full_resp_t mst_resp_i,
    output logic       busy_o
);
    localparam int unsigned WrCntW       = $clog2(AxiMaxWriteTxns + 1);
    localparam int unsigned RdCntW       = $clog2(AxiMaxReadTxns + 1);
    localparam logic [2:0]  AxSize       = 3'($clog2(AxiDataWidth / 8));
    localparam int unsigned UnusedWidths = AxiAddrWidth + AxiUserWidth;

    logic [WrCntW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [RdCntW-1:0]       rd_cnt_q, rd_cnt_d;
    logic                    busy_q, busy_d;
    logic                    aw_open, ar_open, aw_hs, ar_hs, b_hs, r_hs;
    logic                    b_slv_valid, b_mst_ready, r_slv_valid, r_mst_ready;
    logic [1:0]              b_slv_resp, r_slv_resp;
    logic [AxiDataWidth-1:0] r_slv_data;
    logic                    unused_resp;

    assign unused_resp = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.id,
                           mst_resp_i.r.last, mst_resp_i.r.user};

`ifdef AXI_LITE_TO_AXI_RESP_SPILL_EN
    axi_lite_to_axi_tracked_spill #(.Width(2)) i_b_spill (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (mst_resp_i.b_valid),
        .in_ready_o  (b_mst_ready),
        .in_data_i   (mst_resp_i.b.resp),
        .out_valid_o (b_slv_valid),
        .out_ready_i (slv_req_i.b_ready),
        .out_data_o  (b_slv_resp)
    );
    axi_lite_to_axi_tracked_spill #(.Width(AxiDataWidth + 2)) i_r_spill (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (mst_resp_i.r_valid),
        .in_ready_o  (r_mst_ready),
        .in_data_i   ({mst_resp_i.r.data, mst_resp_i.r.resp}),
        .out_valid_o (r_slv_valid),
        .out_ready_i (slv_req_i.r_ready),
        .out_data_o  ({r_slv_data, r_slv_resp})
    );
`else
    assign b_slv_valid = mst_resp_i.b_valid;
    assign b_slv_resp  = mst_resp_i.b.resp;
    assign b_mst_ready = slv_req_i.b_ready;
    assign r_slv_valid = mst_resp_i.r_valid;
    assign r_slv_data  = mst_resp_i.r.data;
    assign r_slv_resp  = mst_resp_i.r.resp;
    assign r_mst_ready = slv_req_i.r_ready;
`endif

    // A transfer happens on a rising edge where valid and ready are both high; a raised
    // valid stays high with a stable payload until that edge. AW/AR are gated by the
    // registered count, so a response retiring in the same cycle frees its slot only next cycle.
    assign aw_open = (wr_cnt_q != WrCntW'(AxiMaxWriteTxns));
    assign ar_open = (rd_cnt_q != RdCntW'(AxiMaxReadTxns));
    assign aw_hs   = slv_req_i.aw_valid & mst_resp_i.aw_ready & aw_open;
    assign ar_hs   = slv_req_i.ar_valid & mst_resp_i.ar_ready & ar_open;
    assign b_hs    = b_slv_valid & slv_req_i.b_ready;
    assign r_hs    = r_slv_valid & slv_req_i.r_ready;

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = WriteId;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.size  = AxSize;
        mst_req_o.aw.burst = 2'b01;
        mst_req_o.aw.cache = AxCache;
        mst_req_o.aw.prot  = slv_req_i.aw.prot;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_open;
        mst_req_o.w.data   = slv_req_i.w_data;
        mst_req_o.w.strb   = slv_req_i.w_strb;
        mst_req_o.w.last   = 1'b1;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = b_mst_ready;
        mst_req_o.ar.id    = ReadId;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.size  = AxSize;
        mst_req_o.ar.burst = 2'b01;
        mst_req_o.ar.cache = AxCache;
        mst_req_o.ar.prot  = slv_req_i.ar.prot;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_open;
        mst_req_o.r_ready  = r_mst_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b_resp   = b_slv_resp;
        slv_resp_o.b_valid  = b_slv_valid;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
        slv_resp_o.r_data   = r_slv_data;
        slv_resp_o.r_resp   = r_slv_resp;
        slv_resp_o.r_valid  = r_slv_valid;
    end

    // Counters saturate at zero; a stray response is caught by the assertion below.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (aw_hs && !b_hs)                        wr_cnt_d = wr_cnt_q + WrCntW'(1);
        else if (b_hs && !aw_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - WrCntW'(1);
        rd_cnt_d = rd_cnt_q;
        if (ar_hs && !r_hs)                        rd_cnt_d = rd_cnt_q + RdCntW'(1);
        else if (r_hs && !ar_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - RdCntW'(1);
        busy_d = (wr_cnt_d != '0) || (rd_cnt_d != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o = busy_q;

`ifndef SYNTHESIS
    a_b_id: assert property (@(posedge clk_i) disable iff (rst_i)
        mst_resp_i.b_valid |-> (mst_resp_i.b.id == WriteId));
    a_r_id: assert property (@(posedge clk_i) disable iff (rst_i)
        mst_resp_i.r_valid |-> (mst_resp_i.r.id == ReadId));
    a_r_last: assert property (@(posedge clk_i) disable iff (rst_i)
        mst_resp_i.r_valid |-> mst_resp_i.r.last);
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs && wr_cnt_q == '0));
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_hs && rd_cnt_q == '0));
    a_aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.aw_valid && !slv_resp_o.aw_ready) |=> slv_req_i.aw_valid);
    a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.w_valid && !slv_resp_o.w_ready) |=> slv_req_i.w_valid);
    a_ar_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (slv_req_i.ar_valid && !slv_resp_o.ar_ready) |=> slv_req_i.ar_valid);
    a_b_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (mst_resp_i.b_valid && !mst_req_o.b_ready) |=> mst_resp_i.b_valid);
    a_r_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (mst_resp_i.r_valid && !mst_req_o.r_ready) |=> mst_resp_i.r_valid);
`endif
endmodule

// File: tb/tb_axi_lite_to_axi_tracked.sv
// Directed bench for axi_lite_to_axi_tracked; response latency follows AXI_LITE_TO_AXI_RESP_SPILL_EN.
module tb_axi_lite_to_axi_tracked;
    import axi_lite_to_axi_tracked_pkg::*;

    localparam logic [3:0] WID   = 4'h3;
    localparam logic [3:0] RID   = 4'h5;
    localparam logic [3:0] CACHE = 4'b0010;
`ifdef AXI_LITE_TO_AXI_RESP_SPILL_EN
    localparam int RESP_LAT = 1;
`else
    localparam int RESP_LAT = 0;
`endif

    logic       clk;
    logic       rst;
    lite_req_t  slv_req;
    lite_resp_t slv_resp;
    full_req_t  mst_req;
    full_resp_t mst_resp;
    logic       busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    axi_lite_to_axi_tracked #(
        .AxiAddrWidth    (32),
        .AxiDataWidth    (32),
        .AxiIdWidth      (4),
        .AxiUserWidth    (1),
        .AxiMaxWriteTxns (4),
        .AxiMaxReadTxns  (4),
        .WriteId         (WID),
        .ReadId          (RID),
        .AxCache         (CACHE),
        .lite_req_t      (lite_req_t),
        .lite_resp_t     (lite_resp_t),
        .full_req_t      (full_req_t),
        .full_resp_t     (full_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [31:0] a);
        bit ok = 0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = a;
        for (int k = 0; k < 6 && !ok; k++) begin
            #1 ok = slv_resp.aw_ready;
            @(negedge clk);
        end
        slv_req.aw_valid = 1'b0;
        check_val("aw_accept", ok, 1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        slv_req.w_valid = 1'b1;
        slv_req.w_data  = d;
        slv_req.w_strb  = s;
        for (int k = 0; k < 6 && !ok; k++) begin
            #1 ok = slv_resp.w_ready;
            @(negedge clk);
        end
        slv_req.w_valid = 1'b0;
        check_val("w_accept", ok, 1);
    endtask

    task automatic do_ar(input logic [31:0] a);
        bit ok = 0;
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = a;
        for (int k = 0; k < 6 && !ok; k++) begin
            #1 ok = slv_resp.ar_ready;
            @(negedge clk);
        end
        slv_req.ar_valid = 1'b0;
        check_val("ar_accept", ok, 1);
    endtask

    task automatic do_b(input logic [1:0] rs, input string tag);
        bit got = 0;
        bit sent = 0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = WID;
        mst_resp.b.resp  = rs;
        slv_req.b_ready  = 1'b1;
        for (int k = 0; k < 6 && !got; k++) begin
            #1;
            if (slv_resp.b_valid) begin
                got = 1;
                check_val({tag, "_resp"}, slv_resp.b_resp, rs);
            end
            if (mst_req.b_ready && mst_resp.b_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.b_valid = 1'b0;
        end
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        check_val({tag, "_seen"}, got, 1);
    endtask

    task automatic do_r(input logic [31:0] d, input logic [1:0] rs, input string tag);
        bit got = 0;
        bit sent = 0;
        exp_q.push_back(d);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = RID;
        mst_resp.r.data  = d;
        mst_resp.r.resp  = rs;
        mst_resp.r.last  = 1'b1;
        slv_req.r_ready  = 1'b1;
        for (int k = 0; k < 6 && !got; k++) begin
            #1;
            if (slv_resp.r_valid && exp_q.size() > 0) begin
                got = 1;
                check_val({tag, "_data"}, slv_resp.r_data, exp_q.pop_front());
                check_val({tag, "_resp"}, slv_resp.r_resp, rs);
            end
            if (mst_req.r_ready && mst_resp.r_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.r_valid = 1'b0;
        end
        mst_resp.r_valid = 1'b0;
        slv_req.r_ready  = 1'b0;
        check_val({tag, "_seen"}, got, 1);
    endtask

    // Presents a B on the master side and returns once it is visible on the slave side, unaccepted.
    task automatic stage_b();
        bit sent = 0;
        bit vis = 0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = WID;
        mst_resp.b.resp  = 2'b00;
        slv_req.b_ready  = 1'b0;
        for (int k = 0; k < 6 && !vis; k++) begin
            #1;
            vis = slv_resp.b_valid;
            if (mst_req.b_ready && mst_resp.b_valid) sent = 1;
            if (!vis) begin
                @(negedge clk);
                if (sent) mst_resp.b_valid = 1'b0;
            end
        end
        check_val("b_staged", vis, 1);
    endtask

    initial begin
        int  lat, n_acc, r_cyc, a_cyc;
        bit  acc, sent;

        rst      = 1'b1;
        slv_req  = '0;
        mst_resp = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.b.id     = WID;
        mst_resp.r.id     = RID;
        mst_resp.r.last   = 1'b1;

        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_wr_cnt", dut.wr_cnt_q, 0);
        check_val("rst_rd_cnt", dut.rd_cnt_q, 0);
        check_val("rst_valids", {mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                                 slv_resp.b_valid, slv_resp.r_valid}, 0);
        check_val("rst_aw_ready", slv_resp.aw_ready, 1);
        check_val("rst_ar_ready", slv_resp.ar_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single write
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h0000_1000;
        slv_req.aw.prot  = 3'b010;
        slv_req.w_valid  = 1'b1;
        slv_req.w_data   = 32'hDEAD_BEEF;
        slv_req.w_strb   = 4'hF;
        #1;
        check_val("wr_aw_valid", mst_req.aw_valid, 1);
        check_val("wr_aw_addr", mst_req.aw.addr, 32'h0000_1000);
        check_val("wr_aw_id", mst_req.aw.id, WID);
        check_val("wr_aw_len", mst_req.aw.len, 0);
        check_val("wr_aw_size", mst_req.aw.size, 2);
        check_val("wr_aw_burst", mst_req.aw.burst, 2'b01);
        check_val("wr_aw_cache", mst_req.aw.cache, CACHE);
        check_val("wr_aw_prot", mst_req.aw.prot, 3'b010);
        check_val("wr_aw_zero", {mst_req.aw.lock, mst_req.aw.qos, mst_req.aw.region,
                                 mst_req.aw.atop, mst_req.aw.user}, 0);
        check_val("wr_w_data", mst_req.w.data, 32'hDEAD_BEEF);
        check_val("wr_w_strb", mst_req.w.strb, 4'hF);
        check_val("wr_w_last", mst_req.w.last, 1);
        check_val("wr_aw_ready", slv_resp.aw_ready, 1);
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b0;
        check_val("wr_busy_1", busy, 1);
        check_val("wr_cnt_1", dut.wr_cnt_q, 1);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.resp  = 2'b00;
        slv_req.b_ready  = 1'b1;
        lat  = -1;
        sent = 0;
        for (int k = 0; k < 5 && lat < 0; k++) begin
            #1;
            if (slv_resp.b_valid) begin
                lat = k;
                check_val("wr_b_resp", slv_resp.b_resp, 2'b00);
            end
            if (mst_req.b_ready && mst_resp.b_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.b_valid = 1'b0;
        end
        mst_resp.b_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        check_val("wr_b_latency", lat, RESP_LAT);
        check_val("wr_cnt_0", dut.wr_cnt_q, 0);
        check_val("wr_busy_0", busy, 0);

        // Read limit: four accepted, fifth held off until one R retires
        n_acc = 0;
        slv_req.ar_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            slv_req.ar.addr = 32'h2000 + 32'(n_acc * 4);
            #1 acc = slv_resp.ar_ready;
            if (i == 4) begin
                check_val("ar5_ready", acc, 0);
                check_val("ar5_mst_valid", mst_req.ar_valid, 0);
            end
            if (acc) n_acc++;
            @(negedge clk);
        end
        check_val("ar_accepted", n_acc, 4);
        check_val("rd_cnt_full", dut.rd_cnt_q, 4);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'h0000_AAAA;
        mst_resp.r.resp  = 2'b00;
        slv_req.r_ready  = 1'b1;
        r_cyc = -1;
        a_cyc = -1;
        sent  = 0;
        for (int k = 0; k < 8 && a_cyc < 0; k++) begin
            #1;
            if (slv_resp.r_valid && slv_req.r_ready && r_cyc < 0) begin
                r_cyc = k;
                check_val("lim_r_data", slv_resp.r_data, 32'h0000_AAAA);
            end
            if (slv_resp.ar_ready) a_cyc = k;
            if (mst_req.r_ready && mst_resp.r_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.r_valid = 1'b0;
            if (r_cyc >= 0) slv_req.r_ready = 1'b0;
        end
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        slv_req.r_ready  = 1'b0;
        check_val("ar5_after_r", a_cyc - r_cyc, 1);
        check_val("rd_cnt_refill", dut.rd_cnt_q, 4);
        for (int i = 0; i < 4; i++) do_r(32'hC0DE_0000 + 32'(i), 2'b00, "drain_r");
        check_val("rd_cnt_drained", dut.rd_cnt_q, 0);

        // Simultaneous AW and B handshakes
        do_aw(32'h100);
        do_aw(32'h104);
        check_val("sim_cnt_pre", dut.wr_cnt_q, 2);
        stage_b();
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h108;
        slv_req.b_ready  = 1'b1;
        #1 check_val("sim_aw_ready", slv_resp.aw_ready, 1);
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        slv_req.b_ready  = 1'b0;
        mst_resp.b_valid = 1'b0;
        check_val("sim_cnt_same", dut.wr_cnt_q, 2);
        do_aw(32'h10C);
        do_aw(32'h110);
        check_val("max_cnt", dut.wr_cnt_q, 4);
        stage_b();
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h114;
        slv_req.b_ready  = 1'b1;
        #1;
        check_val("max_aw_ready", slv_resp.aw_ready, 0);
        check_val("max_aw_mst_valid", mst_req.aw_valid, 0);
        @(negedge clk);
        slv_req.b_ready  = 1'b0;
        mst_resp.b_valid = 1'b0;
        check_val("max_cnt_freed", dut.wr_cnt_q, 3);
        #1 check_val("max_aw_next", slv_resp.aw_ready, 1);
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        check_val("max_cnt_refill", dut.wr_cnt_q, 4);
        for (int i = 0; i < 4; i++) do_b(2'b00, "drain_b");
        check_val("wr_cnt_drained", dut.wr_cnt_q, 0);

        // W ahead of AW
        slv_req.w_valid = 1'b1;
        slv_req.w_data  = 32'h0000_A5A5;
        slv_req.w_strb  = 4'h3;
        #1;
        check_val("wfirst_valid", mst_req.w_valid, 1);
        check_val("wfirst_last", mst_req.w.last, 1);
        check_val("wfirst_data", mst_req.w.data, 32'h0000_A5A5);
        check_val("wfirst_ready", slv_resp.w_ready, 1);
        check_val("wfirst_no_aw", mst_req.aw_valid, 0);
        @(negedge clk);
        slv_req.w_valid = 1'b0;
        repeat (2) @(negedge clk);
        do_aw(32'h0000_3000);
        do_b(2'b00, "wfirst_b");
        check_val("wfirst_cnt", dut.wr_cnt_q, 0);

        // SLVERR with slave back-pressure
        do_ar(32'h0000_4000);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'h1234_5678;
        mst_resp.r.resp  = 2'b10;
        slv_req.r_ready  = 1'b0;
        sent = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k >= 1) begin
                check_val("bp_valid", slv_resp.r_valid, 1);
                check_val("bp_data", slv_resp.r_data, 32'h1234_5678);
                check_val("bp_resp", slv_resp.r_resp, 2'b10);
                check_val("bp_cnt", dut.rd_cnt_q, 1);
            end
            if (mst_req.r_ready && mst_resp.r_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.r_valid = 1'b0;
        end
        slv_req.r_ready = 1'b1;
        #1;
        check_val("bp_final_valid", slv_resp.r_valid, 1);
        if (mst_req.r_ready && mst_resp.r_valid) sent = 1;
        @(negedge clk);
        if (sent) mst_resp.r_valid = 1'b0;
        check_val("bp_cnt_done", dut.rd_cnt_q, 0);
        #1 check_val("bp_no_dup", slv_resp.r_valid, 0);
        @(negedge clk);
        slv_req.r_ready = 1'b0;
        #1 check_val("bp_no_dup2", slv_resp.r_valid, 0);
        @(negedge clk);

        // Asynchronous reset with reads outstanding
        do_ar(32'h5000);
        do_ar(32'h5004);
        do_ar(32'h5008);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'h0BAD_0BAD;
        mst_resp.r.resp  = 2'b00;
        sent = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (mst_req.r_ready && mst_resp.r_valid) sent = 1;
            @(negedge clk);
            if (sent) mst_resp.r_valid = 1'b0;
        end
        check_val("ar_rst_cnt_pre", dut.rd_cnt_q, 3);
        check_val("ar_rst_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        mst_resp.r_valid = 1'b0;
        #1;
        check_val("ar_rst_cnt", dut.rd_cnt_q, 0);
        check_val("ar_rst_busy", busy, 0);
        check_val("ar_rst_valids", {slv_resp.r_valid, slv_resp.b_valid, mst_req.ar_valid,
                                    mst_req.aw_valid, mst_req.w_valid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_ar(32'h6000);
        check_val("post_rst_rd_cnt", dut.rd_cnt_q, 1);
        do_r(32'hFEED_F00D, 2'b00, "post_rst_r");
        do_w(32'h0000_0042, 4'h1);
        do_aw(32'h6100);
        do_b(2'b00, "post_rst_b");
        check_val("post_rst_cnts", {dut.wr_cnt_q, dut.rd_cnt_q}, 0);
        check_val("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
